// File: rtl/clk_reset_sequencer.sv
// Clock/reset sequencer: drives the MMCM reset, qualifies LOCKED through a
// synchroniser and releases the downstream domain resets one by one.
module clk_reset_sequencer #(
    parameter int NUM_DOMAINS    = 3,
    parameter int SYNC_STAGES    = 2,
    parameter int RST_CYCLES     = 4,
    parameter int LOCK_TIMEOUT   = 64,
    parameter int STABLE_CYCLES  = 16,
    parameter int STAGGER_CYCLES = 8,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               locked,
    input  logic                               restart,
    output logic                               mmcm_reset,
    output logic [NUM_DOMAINS-1:0]             domain_reset,
    output logic                               ready,
    output logic                               fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
    output logic [7:0]                         lost_lock_count
);

    localparam int RC_W    = $clog2(MAX_RETRIES + 1);
    localparam int MAX_A   = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_B   = (STABLE_CYCLES > STAGGER_CYCLES) ? STABLE_CYCLES : STAGGER_CYCLES;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAIL      = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [RC_W-1:0]        retry_q, retry_d;
    logic [7:0]             lost_q, lost_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [NUM_DOMAINS-1:0] dom_q, dom_d;
    logic                   mmcm_q, mmcm_d;
    logic                   ready_q, ready_d;
    logic                   fail_q, fail_d;

    logic                   locked_sync;
    logic                   retries_spent;
    logic [NUM_DOMAINS-1:0] dom_step;

    assign locked_sync   = sync_q[SYNC_STAGES-1];
    assign retries_spent = (retry_q == RC_W'(MAX_RETRIES));
    // Reset bits are always a contiguous run at the top, so clearing the
    // lowest set bit releases the next domain in index order.
    assign dom_step      = dom_q & (dom_q - NUM_DOMAINS'(1));

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], locked};
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        lost_d  = lost_q;
        case (state_q)
            PLL_RST: begin
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LOCK: begin
                if (locked_sync) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    cnt_d = '0;
                    if (retries_spent) begin
                        state_d = FAIL;
                    end else begin
                        state_d = PLL_RST;
                        retry_d = retry_q + RC_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE: begin
                if (!locked_sync) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (dom_step == '0) begin
                        state_d = RUN;
                        retry_d = '0;
                    end else begin
                        state_d = RELEASE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RELEASE: begin
                if (!locked_sync) begin
                    cnt_d = '0;
                    if (retries_spent) begin
                        state_d = FAIL;
                    end else begin
                        state_d = PLL_RST;
                        retry_d = retry_q + RC_W'(1);
                    end
                end else if (cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (dom_step == '0) begin
                        state_d = RUN;
                        retry_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                // Restart outranks a simultaneous lock loss and is not counted.
                if (restart || !locked_sync) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                    retry_d = '0;
                    if (!restart && lost_q != 8'hFF) begin
                        lost_d = lost_q + 8'd1;
                    end
                end
            end
            FAIL: begin
                if (restart) begin
                    state_d = PLL_RST;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so they move with it.
        mmcm_d  = (state_d == PLL_RST) || (state_d == FAIL);
        ready_d = (state_d == RUN);
        fail_d  = (state_d == FAIL);
        dom_d   = '1;
        if (state_d == RUN) begin
            dom_d = '0;
        end else if (state_d == RELEASE) begin
            if (state_q != RELEASE || cnt_q == CNT_W'(STAGGER_CYCLES - 1)) begin
                dom_d = dom_step;
            end else begin
                dom_d = dom_q;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PLL_RST;
            cnt_q   <= '0;
            retry_q <= '0;
            lost_q  <= '0;
            sync_q  <= '0;
            dom_q   <= '1;
            mmcm_q  <= 1'b1;
            ready_q <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            lost_q  <= lost_d;
            sync_q  <= sync_d;
            dom_q   <= dom_d;
            mmcm_q  <= mmcm_d;
            ready_q <= ready_d;
            fail_q  <= fail_d;
        end
    end

    assign mmcm_reset      = mmcm_q;
    assign domain_reset    = dom_q;
    assign ready           = ready_q;
    assign fail            = fail_q;
    assign retry_count     = retry_q;
    assign lost_lock_count = lost_q;

endmodule
